// File: rtl/inst_axi_rd_bridge.sv
// Fetch-port (req/addr_ok/data_ok) to AXI4 read bridge: one outstanding single-beat read, registered data_ok.
// Optional macro INST_BRIDGE_ERR_EN: flag SLVERR/DECERR on inst_bus_err and zero inst_rdata on error.
module inst_axi_rd_bridge #(
    parameter int ID_WIDTH  = 4,
    parameter int INST_ARID = 0
) (
    input  logic                clk,
    input  logic                rst,
    // fetch-stage instruction port
    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [31:0]         inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [31:0]         inst_rdata,
    output logic                inst_bus_err,
    // AXI4 read address channel
    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    // AXI4 read data channel
    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    // FSM state for observation: 0=IDLE 1=AR 2=R 3=RESP
    output logic [1:0]          dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // once raised, arvalid and araddr/arsize hold steady until arready, and rready is only high in R.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] rdata_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        data_ok_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_q    <= 32'd0;
            size_q    <= 2'd0;
            rdata_q   <= 32'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            data_ok_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_ok_q <= 1'b0;
                    if (inst_req) begin
                        addr_q    <= inst_addr;
                        size_q    <= inst_size;
                        arvalid_q <= 1'b1;
                        state     <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready_q  <= 1'b0;
                        rdata_q   <= rdata;
                        data_ok_q <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    data_ok_q <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    data_ok_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef INST_BRIDGE_ERR_EN
    // SLVERR (2'b10) and DECERR (2'b11) both have rresp[1] set, so only that bit is kept.
    logic resp_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_err_q <= 1'b0;
        end else if (state == R && rvalid) begin
            resp_err_q <= rresp[1];
        end
    end

    assign inst_bus_err = (state == RESP) && resp_err_q;
    assign inst_rdata   = resp_err_q ? 32'd0 : rdata_q;
`else
    assign inst_bus_err = 1'b0;
    assign inst_rdata   = rdata_q;
`endif

    // Gated by rst so no request is acknowledged while the core is held in reset.
    assign inst_addr_ok = rst && (state == IDLE) && inst_req;
    assign inst_data_ok = data_ok_q;

    assign arid    = ID_WIDTH'(INST_ARID);
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign dbg_state = state;

    // Every request is a read; response ID and rlast carry no information for single-beat reads.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, inst_wr, rid, rlast, rresp};

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
- Slave side: the fetch stage's SRAM-like instruction port (req / addr_ok / data_ok).
- Master side: one AXI4 read transaction per accepted request.
- Sits between the fetch-stage instruction port and the AXI crossbar. One outstanding transaction, single-beat only, no write channels.
- Read data and data_ok are registered, so the fetch stage sees a clean one-cycle data_ok pulse.

Parameters:
ID_WIDTH, 4, width of arid/rid
INST_ARID, 0, constant ID driven on arid

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low (core-wide reset net)
inst_req  input  1  fetch request valid
inst_wr  input  1  write flag; ignored, every request is a read
inst_size  input  2  transfer size (2'b10 = word)
inst_addr  input  32  fetch physical address
inst_addr_ok  output  1  request accepted this cycle
inst_data_ok  output  1  read data valid, one-cycle pulse
inst_rdata  output  32  read data, valid when inst_data_ok=1
inst_bus_err  output  1  AXI error response flag (see Optional Feature)
arid  output  ID_WIDTH  = INST_ARID
araddr  output  32  latched inst_addr
arlen  output  8  constant 0
arsize  output  3  {1'b0, latched inst_size}
arburst  output  2  constant 2'b01
arlock, arcache, arprot  output  2/4/3  constant 0
arvalid  output  1  read address valid
arready  input  1  slave accepts address
rid  input  ID_WIDTH  response ID (not checked)
rdata  input  32  read data
rresp  input  2  read response
rlast  input  1  last beat (always 1 for arlen=0, not checked)
rvalid  input  1  read data valid
rready  output  1  master accepts data

Behaviour:
- Reset (rst=0, async): state=IDLE; arvalid, rready, inst_addr_ok, inst_data_ok, inst_bus_err = 0; araddr, size and rdata registers = 0. Reset mid-transaction discards the transaction silently; no data_ok is produced.
- FSM states: IDLE, AR, R, RESP.
- IDLE:
  - inst_addr_ok = inst_req (combinational).
  - On inst_req=1: latch inst_addr and inst_size, go to AR.
  - inst_wr is not examined.
- AR:
  - arvalid=1; araddr/arsize stay stable until accepted.
  - arvalid/araddr never drop or change before arready.
  - On arready=1: go to R.
- R:
  - rready=1.
  - On rvalid=1: capture rdata into the rdata register, capture rresp, go to RESP.
  - rready is never asserted outside R.
- RESP:
  - inst_data_ok=1 for exactly this one cycle; inst_rdata = captured data.
  - Unconditionally go to IDLE.
  - inst_addr_ok=0 in RESP, so the next request is accepted at the earliest in the following cycle (IDLE).
- inst_addr_ok is 0 in AR, R and RESP; at most one transaction is outstanding.
- inst_rdata holds its last value outside RESP; consumers only sample it with data_ok.
- Minimum latency: request accepted at cycle N; arvalid at N+1; with arready=1 at N+1 and rvalid=1 at N+2, inst_data_ok at N+3.
- Back-to-back: next addr_ok earliest at N+4, so throughput is 1 fetch per 4 cycles minimum.
- Stalls: arready or rvalid held low for any number of cycles keeps the FSM in AR or R, with all outputs stable.
- Flushes/cancellation are handled upstream. The bridge always completes an accepted request and always produces exactly one data_ok per addr_ok.

Optional Feature:
- Macro INST_BRIDGE_ERR_EN.
- Defined:
  - rresp captured in R.
  - inst_bus_err=1 in RESP when captured rresp is SLVERR (2'b10) or DECERR (2'b11), 0 otherwise.
  - inst_rdata is forced to 32'd0 on error.
- Undefined: rresp ignored; inst_bus_err tied to 0; inst_rdata always equals captured rdata.

Test Plan:
- Reset: hold rst=0 with inst_req=1 -> addr_ok=0, arvalid=0, rready=0, data_ok=0; release -> addr_ok=1 in the first IDLE cycle.
- Single fetch: inst_req with inst_addr=0xBFC00000, arready=1, rvalid=1 next cycle with rdata=0x3C1D0010 -> araddr=0xBFC00000, arsize=3'b010, arlen=0, arid=INST_ARID; data_ok pulse 3 cycles after addr_ok with inst_rdata=0x3C1D0010.
- AR stall: arready low 5 cycles -> arvalid held, araddr stable, addr_ok stays 0; data_ok follows 2 cycles after arready.
- R stall plus back-to-back: rvalid delayed 4 cycles, inst_req held high for addresses 0x1000 and 0x1004 -> exactly two addr_ok/data_ok pairs, in order, no overlap, rready high only in R.
- Mid-transaction reset: rst pulsed low while in R -> FSM in IDLE, no data_ok; a subsequent fetch completes normally.
- Error (INST_BRIDGE_ERR_EN defined): rresp=2'b10, rdata=0xDEADBEEF -> inst_bus_err=1 and inst_rdata=0 with data_ok. Undefined: inst_bus_err=0 and inst_rdata=0xDEADBEEF.
